// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with fixed-latency memory and one-entry output slot
// Fetches one word per MEM_LAT cycles from a combinational instruction memory,
// holds it in a single output register until consumed, and redirects on branch.

module fetch_ctrl #(
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

  // Last wait-count value: the memory word is ready once cnt reaches this.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  // Word-aligned reset address; byte offset bits are never meaningful.
  localparam logic [31:0] PC_RESET_ALIGNED = PC_RESET & ~32'd3;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic [31:0] pc_plus4;

  assign slot_free = !valid_q || !freeze;
  assign pc_plus4  = pc_q + 32'd4;

  assign mem_addr   = pc_q;
  assign mem_req    = (state_q != IDLE);
  assign inst_out   = inst_q;
  assign pc_out     = pco_q;
  assign inst_valid = valid_q;

  // State and datapath registers; reset discards any fetch in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= PC_RESET_ALIGNED;
      inst_q  <= 32'd0;
      pco_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: branch redirect first, then wait counting, completion or stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    valid_d = valid_q;

    if (branch_taken) begin
      pc_d    = branch_addr & ~32'd3;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      // Consumer took the held word this cycle; completion below may refill it.
      if (valid_q && !freeze) begin
        valid_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH, STALL: begin
          if (cnt_q < LAT_M1) begin
            cnt_d = cnt_q + 4'd1;
          end else if (slot_free) begin
            inst_d  = mem_rdata;
            pco_d   = pc_plus4;
            pc_d    = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = 4'd0;
            state_d = FETCH;
          end else begin
            // Word is ready but the slot is occupied: hold address and count.
            state_d = STALL;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles mem_addr is held per fetch; legal range 1..15.
REQ-002 SHALL have parameter PC_RESET, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: the one clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port freeze, input, 1: consumer stall; the held instruction is not consumed this cycle.
REQ-006 SHALL have port branch_taken, input, 1: redirect fetch this cycle.
REQ-007 SHALL have port branch_addr, input, 32: redirect target.
REQ-008 SHALL have port mem_addr, output, 32: byte address to instruction memory; always equals internal pc.
REQ-009 SHALL have port mem_req, output, 1: high in FETCH and STALL states.
REQ-010 SHALL have port mem_rdata, input, 32: instruction word from memory, combinational from mem_addr.
REQ-011 SHALL have port inst_out, output, 32: registered fetched instruction.
REQ-012 SHALL have port pc_out, output, 32: registered fetch address of inst_out plus 4.
REQ-013 SHALL have port inst_valid, output, 1: inst_out/pc_out hold an unconsumed instruction.

Function
REQ-014 SHALL implement states IDLE, FETCH and STALL, plus a wait counter cnt of 4 bits.
REQ-015 IDLE: mem_req=0; SHALL go to FETCH on the next edge unconditionally.
REQ-016 FETCH: cnt increments each edge while cnt < MEM_LAT-1.
REQ-017 Slot free SHALL mean (!inst_valid || !freeze).
REQ-018 Completion occurs at an edge in FETCH/STALL with cnt==MEM_LAT-1 and the slot free.
REQ-019 On completion the block SHALL set inst_out<=mem_rdata, pc_out<=pc+4, pc<=pc+4, inst_valid<=1, cnt<=0, state<=FETCH.
REQ-020 At cnt==MEM_LAT-1 with the slot not free, the block SHALL go to or stay in STALL, hold cnt and pc, and keep mem_req=1.
REQ-021 On an edge with inst_valid=1, freeze=0 and no completion, the block SHALL clear inst_valid.
REQ-022 While freeze=1 and inst_valid=1, inst_out, pc_out and inst_valid SHALL remain unchanged.
REQ-023 With MEM_LAT=1 and freeze=0, the block SHALL complete one fetch per cycle, keeping inst_valid continuously high.
REQ-024 On any edge with branch_taken=1, in any state, the block SHALL set pc<={branch_addr[31:2],2'b00}, cnt<=0, inst_valid<=0 and state<=FETCH, discarding any fetch in progress.
REQ-025 branch_taken SHALL take priority over freeze, over completion and over IDLE sequencing.
REQ-026 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 pc[1:0] SHALL always be 2'b00; PC_RESET low bits SHALL be forced to 0.
REQ-028 Fetch latency SHALL be MEM_LAT cycles from first presentation of an address to inst_valid, absent stalls.

Reset
REQ-029 While rst=1, the block SHALL immediately, without a clock edge, set state=IDLE, cnt=0, pc=PC_RESET, mem_req=0, inst_out=0, pc_out=0 and inst_valid=0.
REQ-030 Reset asserted mid-fetch or mid-stall SHALL discard the fetch in progress; after release, fetching SHALL restart at PC_RESET.
REQ-031 Deassertion of rst SHALL be followed by exactly one IDLE cycle before the first FETCH cycle.

Verification
REQ-032 Free run (MEM_LAT=2, memory word = address, freeze=0) -> edge 0 after release: IDLE; inst_valid high from cycle 3 with inst_out=0, pc_out=4; then inst_out=4, pc_out=8 in cycle 5.
REQ-033 freeze=1 for 4 cycles while inst_valid=1 -> inst_out stable; state STALL with mem_addr=4, pc not advancing; first edge after release completes with inst_out=4.
REQ-034 branch_taken=1, branch_addr=32'h103 -> inst_valid=0 in the next cycle with mem_addr=32'h100; two cycles later inst_out=32'h100 and pc_out=32'h104.
REQ-035 branch_taken=1 and freeze=1 on the same edge with inst_valid=1 -> branch wins: inst_valid=0 and mem_addr=branch target.
REQ-036 Branch to 32'hFFFF_FFFC -> pc_out=32'h0000_0000, and the next mem_addr is 0.
REQ-037 rst pulsed between clock edges during FETCH cnt=1 -> all outputs 0 before the next edge; then one IDLE cycle, and the first instruction comes from PC_RESET; with MEM_LAT=1, back-to-back inst_valid with pc_out stepping by 4 each cycle.
